// File: rtl/rv32i_types.sv
// Shared pipeline types: PC-control state and the bubble ControlWord injected on flush.
package rv32i_types;

    typedef enum logic {
        RUN  = 1'b0,
        DROP = 1'b1
    } pc_state_t;

    typedef struct packed {
        logic [6:0] opcode;
        logic [2:0] funct3;
        logic       load_regfile;
        logic       dmem_read;
        logic       dmem_write;
    } control_word_t;

    // addi x0, x0, 0 with every side effect disabled
    localparam control_word_t BUBBLE_CW = '{
        opcode:       7'b0010011,
        funct3:       3'b000,
        load_regfile: 1'b0,
        dmem_read:    1'b0,
        dmem_write:   1'b0
    };

endpackage

// File: rtl/pipeline_control_hazard_detect.sv
// Load-use hazard: an EX-stage load writes a register the ID stage is about to read.
module hazard_detect (
    input  logic       ex_load,
    input  logic [4:0] ex_rd,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    output logic       hazard
);

    assign hazard = ex_load & (ex_rd != 5'd0) & ((ex_rd == id_rs1) | (ex_rd == id_rs2));

endmodule

// File: rtl/pipeline_control.sv
// Pipeline load/flush sequencing with stale-fetch discard after a redirect
// that leaves an instruction fetch outstanding, plus saturating perf counters.
module pipeline_control
    import rv32i_types::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             imem_resp,
    input  logic             mem_dmem_req,
    input  logic             dmem_resp,
    input  logic             ex_redirect,
    input  logic             ex_load,
    input  logic [4:0]       ex_rd,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    output logic             load_pc,
    output logic             load_if_id,
    output logic             load_id_ex,
    output logic             load_ex_mem,
    output logic             load_mem_wb,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic             redirect_ack,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] bubble_count,
    output logic [CNT_W-1:0] flush_count
);

    pc_state_t state, state_nxt;
    logic      dmem_stall, imem_stall, hazard, bubble;

    assign dmem_stall = mem_dmem_req & ~dmem_resp;
    assign imem_stall = ~imem_resp;

    hazard_detect u_hazard (
        .ex_load (ex_load),
        .ex_rd   (ex_rd),
        .id_rs1  (id_rs1),
        .id_rs2  (id_rs2),
        .hazard  (hazard)
    );

    always_comb begin
        load_pc      = 1'b0;
        load_if_id   = 1'b0;
        load_id_ex   = 1'b0;
        load_ex_mem  = 1'b0;
        load_mem_wb  = 1'b0;
        flush_if_id  = 1'b0;
        flush_id_ex  = 1'b0;
        redirect_ack = 1'b0;
        bubble       = 1'b0;
        state_nxt    = state;
        if (!rst) begin
            unique case (state)
                RUN: begin
                    if (dmem_stall) begin
                        // whole pipe frozen
                    end else if (ex_redirect) begin
                        {load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb} = 5'b11111;
                        flush_if_id  = 1'b1;
                        flush_id_ex  = 1'b1;
                        redirect_ack = 1'b1;
                        // an unanswered fetch must be thrown away when it lands
                        if (!imem_resp) state_nxt = DROP;
                    end else if (imem_stall) begin
                        // frozen waiting on fetch
                    end else if (hazard) begin
                        {load_id_ex, load_ex_mem, load_mem_wb} = 3'b111;
                        flush_id_ex = 1'b1;
                        bubble      = 1'b1;
                    end else begin
                        {load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb} = 5'b11111;
                    end
                end
                DROP: begin
                    // front end holds; back end drains with bubbles
                    if (!dmem_stall) begin
                        {load_id_ex, load_ex_mem, load_mem_wb} = 3'b111;
                        flush_id_ex = 1'b1;
                    end
                    if (imem_resp) state_nxt = RUN;
                end
                default: state_nxt = RUN;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= RUN;
            stall_count  <= '0;
            bubble_count <= '0;
            flush_count  <= '0;
        end else begin
            state <= state_nxt;
            if (!load_mem_wb && !(&stall_count))
                stall_count <= stall_count + CNT_W'(1);
            if (bubble && !(&bubble_count))
                bubble_count <= bubble_count + CNT_W'(1);
            if (redirect_ack && !(&flush_count))
                flush_count <= flush_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipeline_control.sv
// Directed and random stimulus against a rule-table reference of pipeline_control.
module tb_pipeline_control;

    localparam int CNT_W = 8;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             imem_resp, mem_dmem_req, dmem_resp, ex_redirect, ex_load;
    logic [4:0]       ex_rd, id_rs1, id_rs2;
    logic             load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb;
    logic             flush_if_id, flush_id_ex, redirect_ack;
    logic [CNT_W-1:0] stall_count, bubble_count, flush_count;

    pipeline_control #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .imem_resp(imem_resp), .mem_dmem_req(mem_dmem_req),
        .dmem_resp(dmem_resp), .ex_redirect(ex_redirect), .ex_load(ex_load),
        .ex_rd(ex_rd), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .load_pc(load_pc), .load_if_id(load_if_id), .load_id_ex(load_id_ex),
        .load_ex_mem(load_ex_mem), .load_mem_wb(load_mem_wb),
        .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex), .redirect_ack(redirect_ack),
        .stall_count(stall_count), .bubble_count(bubble_count), .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    // Reference: which rule applies this cycle, and the output pattern of each rule.
    // Pattern bits: {ack, flush_id_ex, flush_if_id, mem_wb, ex_mem, id_ex, if_id, pc}
    localparam int R_DSTALL = 0, R_REDIR = 1, R_ISTALL = 2, R_HAZ = 3, R_ADV = 4, R_DRAIN = 5;

    bit m_drop;
    int m_stall, m_bubble, m_flush;
    int checks = 0, errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick_rule();
        bit dst, haz;
        dst = mem_dmem_req && !dmem_resp;
        haz = ex_load && ex_rd != 0 && (ex_rd == id_rs1 || ex_rd == id_rs2);
        if (m_drop) return dst ? R_DSTALL : R_DRAIN;
        if (dst)          return R_DSTALL;
        if (ex_redirect)  return R_REDIR;
        if (!imem_resp)   return R_ISTALL;
        if (haz)          return R_HAZ;
        return R_ADV;
    endfunction

    function automatic logic [7:0] rule_out(input int r);
        case (r)
            R_REDIR:           return 8'hFF;
            R_HAZ, R_DRAIN:    return 8'h5C;
            R_ADV:             return 8'h1F;
            default:           return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] dut_out();
        return {redirect_ack, flush_id_ex, flush_if_id, load_mem_wb,
                load_ex_mem, load_id_ex, load_if_id, load_pc};
    endfunction

    task automatic check_counters(input string tag);
        chk({tag, ".stall"},  32'(stall_count),  32'(m_stall));
        chk({tag, ".bubble"}, 32'(bubble_count), 32'(m_bubble));
        chk({tag, ".flush"},  32'(flush_count),  32'(m_flush));
    endtask

    // One clock: drive, check combinational outputs, clock, advance model, check counters.
    task automatic cycle(input string tag, input bit mreq, dresp, iresp, redir, eload,
                         input logic [4:0] erd, rs1, rs2);
        int r;
        logic [7:0] e;
        mem_dmem_req = mreq; dmem_resp = dresp; imem_resp = iresp;
        ex_redirect = redir; ex_load = eload; ex_rd = erd; id_rs1 = rs1; id_rs2 = rs2;
        #1;
        r = pick_rule();
        e = rule_out(r);
        chk({tag, ".outs"}, 32'(dut_out()), 32'(e));
        @(posedge clk);
        if (!e[4] && m_stall < CMAX)  m_stall++;
        if (r == R_HAZ && m_bubble < CMAX) m_bubble++;
        if (e[7] && m_flush < CMAX)   m_flush++;
        if (m_drop) m_drop = !iresp;
        else if (r == R_REDIR) m_drop = !iresp;
        #1;
        check_counters(tag);
    endtask

    task automatic pulse_reset(input string tag);
        rst = 1'b1;
        #1;
        m_drop = 0; m_stall = 0; m_bubble = 0; m_flush = 0;
        chk({tag, ".outs"}, 32'(dut_out()), 32'h0);
        check_counters(tag);
        #1 rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        {imem_resp, mem_dmem_req, dmem_resp, ex_redirect, ex_load} = '0;
        ex_rd = '0; id_rs1 = '0; id_rs2 = '0;
        m_drop = 0; m_stall = 0; m_bubble = 0; m_flush = 0;
        #1;
        chk("reset.outs", 32'(dut_out()), 32'h0);
        check_counters("reset");
        #11 rst = 1'b0;

        // straight-line code
        for (int i = 0; i < 4; i++) cycle("straight", 0, 0, 1, 0, 0, 5'd1, 5'd2, 5'd3);
        chk("straight.cnt_zero", 32'(stall_count + bubble_count + flush_count), 32'h0);

        // load-use hazard on rs2, then x0 never hazards
        cycle("haz_rs2", 0, 0, 1, 0, 1, 5'd5, 5'd7, 5'd5);
        chk("haz_rs2.bubble1", 32'(bubble_count), 32'd1);
        cycle("haz_x0", 0, 0, 1, 0, 1, 5'd0, 5'd0, 5'd3);
        chk("haz_x0.bubble1", 32'(bubble_count), 32'd1);

        // dmem stall masks a pending redirect for 3 cycles
        pulse_reset("rst_a");
        for (int i = 0; i < 3; i++) cycle("dstall_redir", 1, 0, 1, 1, 0, 5'd0, 5'd0, 5'd0);
        cycle("dresp_ack", 1, 1, 1, 1, 0, 5'd0, 5'd0, 5'd0);
        chk("dstall.stall3", 32'(stall_count), 32'd3);
        chk("dstall.flush1", 32'(flush_count), 32'd1);

        // redirect with fetch outstanding: two DROP cycles, then RUN
        cycle("redir_drop", 0, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0);
        cycle("drop1", 0, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0);
        chk("drop1.pc", 32'(load_pc), 32'd0);
        cycle("drop2_exit", 0, 0, 1, 1, 0, 5'd0, 5'd0, 5'd0);
        cycle("run_again", 0, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0);
        chk("run_again.pc", 32'(load_pc), 32'd1);

        // redirect beats hazard
        cycle("redir_vs_haz", 0, 0, 1, 1, 1, 5'd9, 5'd9, 5'd0);

        // reset while in DROP with counters nonzero
        cycle("into_drop", 0, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0);
        pulse_reset("rst_drop");
        cycle("post_rst_run", 0, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0);

        // counter saturation
        for (int i = 0; i < CMAX + 4; i++) cycle("sat", 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
        chk("sat.stall", 32'(stall_count), 32'(CMAX));

        // random traffic, narrow register space so hazards are common
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 199) == 0) pulse_reset("rnd_rst");
            cycle("rnd", $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0,
                  $urandom_range(0, 1) == 1, 5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipeline_control.md
PIPELINE_CONTROL -- requirements
Module: pipeline_control

Interface
REQ-001 Parameter: CNT_W, default 32, width of the performance counters.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 imem_resp  input  1  instruction memory returns the fetch for the current PC this cycle.
REQ-005 mem_dmem_req  input  1  MEM-stage ControlWord has dmem_read or dmem_write set.
REQ-006 dmem_resp  input  1  data memory completes the MEM-stage access this cycle.
REQ-007 ex_redirect  input  1  EX stage needs a PC redirect (taken branch/jump); held high until accepted.
REQ-008 ex_load  input  1  EX-stage ControlWord dmem_read.
REQ-009 ex_rd  input  5  EX-stage destination register.
REQ-010 id_rs1, id_rs2  input  5 each  ID-stage source registers.
REQ-011 load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb  output  1 each  load enables for the PC and the four pipeline_stage registers.
REQ-012 flush_if_id, flush_id_ex  output  1 each  select the bubble (NOP ControlWord, load_regfile=0, dmem_read/write=0) into that stage's input; effective only when its load is high.
REQ-013 redirect_ack  output  1  PC takes the EX target this cycle; EX drops ex_redirect next cycle.
REQ-014 stall_count, bubble_count, flush_count  output  CNT_W each  performance counters.

Function
REQ-015 States: RUN and DROP (discard stale in-flight fetch); all outputs except counters are combinational from state and inputs.
REQ-016 dmem_stall = mem_dmem_req & ~dmem_resp; imem_stall = ~imem_resp; hazard = ex_load & (ex_rd != 0) & (ex_rd == id_rs1 | ex_rd == id_rs2).
REQ-017 Priority in RUN, highest first: dmem_stall, ex_redirect, imem_stall, hazard, normal advance.
REQ-018 RUN, dmem_stall: all five loads 0, flushes 0, redirect_ack 0; state RUN.
REQ-019 RUN, ex_redirect, imem_resp=1: all loads 1, flush_if_id=1, flush_id_ex=1, redirect_ack=1; state RUN.
REQ-020 RUN, ex_redirect, imem_resp=0: same outputs as REQ-019; next state DROP.
REQ-021 RUN, imem_stall, no redirect: all loads 0; state RUN.
REQ-022 RUN, hazard only: load_pc=0, load_if_id=0, load_id_ex=1 with flush_id_ex=1, load_ex_mem=1, load_mem_wb=1.
REQ-023 RUN, none of the above: all loads 1, flushes 0.
REQ-024 DROP: load_pc=0, load_if_id=0; if dmem_stall, back loads 0; else load_id_ex=1 with flush_id_ex=1, load_ex_mem=1, load_mem_wb=1; redirect_ack=0; ex_redirect ignored.
REQ-025 DROP exits to RUN on the cycle imem_resp=1 (response discarded); the fetch of the redirect target starts in RUN next cycle.
REQ-026 stall_count +1 each cycle load_mem_wb=0; bubble_count +1 each REQ-022 cycle; flush_count +1 each redirect_ack cycle; all saturate at all-ones.

Reset
REQ-027 rst asserted: state RUN and all counters 0 immediately; all loads, flushes and redirect_ack 0 while rst high.
REQ-028 Reset mid-DROP returns to RUN; the outstanding fetch is owned by the memory side's reset.
REQ-029 First posedge after rst deasserts evaluates as RUN.

Structure
REQ-030 State enum (RUN, DROP) and the bubble ControlWord constant live in rv32i_types.
REQ-031 One combinational sub-module, hazard_detect, computes hazard (REQ-016); everything else is in pipeline_control.

Verification
REQ-032 Straight-line code, imem_resp=1, no dmem: all loads 1 every cycle; counters stay 0.
REQ-033 ex_load=1, ex_rd=5, id_rs2=5: one cycle load_pc=0, load_if_id=0, flush_id_ex=1; bubble_count=1; ex_rd=0 with id_rs1=0 gives no bubble.
REQ-034 mem_dmem_req=1, dmem_resp low 3 cycles with ex_redirect=1: 3 cycles all loads 0, no ack; 4th cycle redirect_ack=1; stall_count=3, flush_count=1.
REQ-035 ex_redirect=1, imem_resp=0: ack that cycle, DROP for 2 cycles until imem_resp=1, load_pc=0 throughout DROP, then RUN.
REQ-036 ex_redirect and hazard same cycle: redirect wins, bubble_count unchanged, flush_count +1.
REQ-037 rst pulsed while in DROP with counters nonzero: state RUN, counters 0 before next posedge.
